// File: rtl/freq_meter_pkg.sv
// Shared timebase constants and types for the frequency meter and
// the tick generator that derives its gate from the same crystal.
package freq_meter_pkg;

    localparam int CRYSTAL_MHZ = 50;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fm_state_t;

    // Clock cycles in a gate of num_sec seconds at crystal_mhz MHz.
    function automatic int gate_cycles(input int crystal_mhz,
                                       input int num_sec);
        return crystal_mhz * 1_000_000 * num_sec;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Brings the asynchronous measured signal into the CLK1 domain and
// emits one single-cycle pulse per rising edge.
module sync_edge (
    input  logic CLK1,
    input  logic arst_n,
    input  logic sig_in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed gate window and latches
// one saturating result per completed window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CRYSTAL     = CRYSTAL_MHZ,
    parameter int NUM_SEC     = 1,
    parameter int GATE_CYCLES = gate_cycles(CRYSTAL, NUM_SEC),
    parameter int C           = 26,
    parameter int W           = 28
) (
    input  logic         CLK1,
    input  logic         arst_n,
    input  logic         sig_in,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         valid,
    output logic         ovf,
    output logic         busy
);

    localparam logic [C-1:0] LAST = C'(GATE_CYCLES - 1);
    localparam logic [W-1:0] MAX  = '1;

    fm_state_t    state;
    fm_state_t    state_nx;
    logic [C-1:0] gate_cnt;
    logic [W-1:0] edge_cnt;
    logic [W-1:0] edge_nx;
    logic         sat;
    logic         lost;
    logic         close;
    logic         pulse;

    sync_edge u_sync (
        .CLK1   (CLK1),
        .arst_n (arst_n),
        .sig_in (sig_in),
        .pulse  (pulse)
    );

    // An edge arriving while the counter sits at MAX is lost.
    always_comb begin
        edge_nx = edge_cnt;
        lost    = 1'b0;
        if (pulse) begin
            if (edge_cnt == MAX) begin
                lost = 1'b1;
            end else begin
                edge_nx = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // en is checked before the terminal count so a drop wins.
    always_comb begin
        state_nx = state;
        close    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (gate_cnt == LAST) begin
                    close = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state != RUN || !en || close) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nx;
            sat      <= sat | lost;
        end
    end

    always_ff @(posedge CLK1 or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= close;
            if (close) begin
                count <= edge_nx;
                ovf   <= sat | lost;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three widths share one stimulus, checked
// against a window/timestamp reference model and directed cases.
module tb_freq_meter;

    localparam int G = 100;

    logic       CLK1   = 1'b0;
    logic       arst_n = 1'b0;
    logic       sig_in = 1'b0;
    logic       en     = 1'b0;
    logic [7:0] count8;
    logic [4:0] count5;
    logic [3:0] count4;
    logic       valid8, valid5, valid4;
    logic       ovf8, ovf5, ovf4;
    logic       busy8, busy5, busy4;

    freq_meter #(.GATE_CYCLES(G), .C(7), .W(8)) dut8 (
        .CLK1(CLK1), .arst_n(arst_n), .sig_in(sig_in), .en(en),
        .count(count8), .valid(valid8), .ovf(ovf8), .busy(busy8)
    );
    freq_meter #(.GATE_CYCLES(G), .C(7), .W(5)) dut5 (
        .CLK1(CLK1), .arst_n(arst_n), .sig_in(sig_in), .en(en),
        .count(count5), .valid(valid5), .ovf(ovf5), .busy(busy5)
    );
    freq_meter #(.GATE_CYCLES(G), .C(7), .W(4)) dut4 (
        .CLK1(CLK1), .arst_n(arst_n), .sig_in(sig_in), .en(en),
        .count(count4), .valid(valid4), .ovf(ovf4), .busy(busy4)
    );

    always #5 CLK1 = ~CLK1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: window timestamps and a list of sampled rises.
    // A rise first sampled at edge k is counted at edge k+2.
    int  rises[$];
    bit  m_run     = 1'b0;
    int  m_start   = 0;
    bit  prev_sig  = 1'b0;
    bit  exp_valid = 1'b0;
    int  exp_c[3]  = '{0, 0, 0};
    bit  exp_o[3]  = '{0, 0, 0};
    int  maxv[3]   = '{255, 31, 15};

    initial begin
        int n;
        forever begin
            @(posedge CLK1);
            cyc++;
            exp_valid = 1'b0;
            if (!arst_n) begin
                m_run    = 1'b0;
                prev_sig = 1'b0;
                rises.delete();
                exp_c    = '{0, 0, 0};
                exp_o    = '{0, 0, 0};
            end else begin
                if (sig_in && !prev_sig) rises.push_back(cyc);
                prev_sig = sig_in;
                if (!m_run) begin
                    if (en) begin
                        m_run   = 1'b1;
                        m_start = cyc;
                        while (rises.size() > 0 && rises[0] + 2 <= m_start)
                            void'(rises.pop_front());
                    end
                end else if (!en) begin
                    m_run = 1'b0;
                end else if (cyc - m_start == G) begin
                    n = 0;
                    foreach (rises[i])
                        if (rises[i] + 2 > m_start && rises[i] + 2 <= cyc)
                            n++;
                    for (int d = 0; d < 3; d++) begin
                        exp_c[d] = (n > maxv[d]) ? maxv[d] : n;
                        exp_o[d] = (n > maxv[d]);
                    end
                    exp_valid = 1'b1;
                    m_start   = cyc;
                    while (rises.size() > 0 && rises[0] + 2 <= m_start)
                        void'(rises.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK1);
            chk("valid8", valid8, exp_valid);
            chk("valid5", valid5, exp_valid);
            chk("valid4", valid4, exp_valid);
            chk("busy", busy8, m_run);
            chk("count8", count8, exp_c[0]);
            chk("ovf8", ovf8, exp_o[0]);
            chk("count5", count5, exp_c[1]);
            chk("ovf5", ovf5, exp_o[1]);
            chk("count4", count4, exp_c[2]);
            chk("ovf4", ovf4, exp_o[2]);
        end
    end

    // Signal generator: hi/lo phase lengths, optionally randomized.
    bit gen_on = 1'b0;
    bit rnd    = 1'b0;
    int hi     = 5;
    int lo     = 5;
    int ph     = 0;

    initial begin
        forever begin
            @(negedge CLK1);
            if (gen_on) begin
                if (ph <= 0) begin
                    sig_in = ~sig_in;
                    if (rnd) begin
                        hi = $urandom_range(2, 8);
                        lo = $urandom_range(2, 8);
                    end
                    ph = sig_in ? hi - 1 : lo - 1;
                end else begin
                    ph--;
                end
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge CLK1);
    endtask

    task automatic wait_valid(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK1);
            if (valid8 === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_valid: none within %0d cycles", maxc);
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int c8;
        int c5;
        bit o5;
        int c4;
        bit o4;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int s;
        int at;
        int at2;
        int seen;

        tbl[0] = '{5, 5, 10, 10, 0, 10, 0};
        tbl[1] = '{2, 2, 25, 25, 0, 15, 1};
        tbl[2] = '{10, 10, 5, 5, 0, 5, 0};
        tbl[3] = '{2, 3, 20, 20, 0, 15, 1};
        tbl[4] = '{5, 5, 10, 10, 0, 10, 0};

        gen_on = 1'b1;
        repeat (20) @(negedge CLK1);
        chk("rst_count", count8, 0);
        chk("rst_valid", valid8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_busy", busy8, 0);

        arst_n = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge CLK1);
            if (valid8 === 1'b1) seen++;
        end
        chk("no_valid_en0", seen, 0);

        s  = cyc + 1;
        en = 1'b1;
        wait_valid(G + 5, at);
        chk("first_latency", at - s, G);
        chk("first_count", count8, 10);
        chk("first_ovf", ovf8, 0);
        wait_valid(G + 5, at2);
        chk("valid_period", at2 - at, G);
        chk("second_count", count8, 10);
        @(negedge CLK1);
        chk("valid_one_cycle", valid8, 0);

        foreach (tbl[i]) begin
            hi = tbl[i].hi;
            lo = tbl[i].lo;
            wait_valid(G + 5, at);
            wait_valid(G + 5, at);
            chk("tbl_c8", count8, tbl[i].c8);
            chk("tbl_o8", ovf8, 0);
            chk("tbl_c5", count5, tbl[i].c5);
            chk("tbl_o5", ovf5, tbl[i].o5);
            chk("tbl_c4", count4, tbl[i].c4);
            chk("tbl_o4", ovf4, tbl[i].o4);
        end

        wait_valid(G + 5, at);
        go_to(at + 60);
        en = 1'b0;
        @(negedge CLK1);
        chk("drop_busy", busy8, 0);
        chk("drop_valid", valid8, 0);
        chk("drop_hold", count8, 10);
        repeat (30) @(negedge CLK1);
        chk("drop_hold_late", count8, 10);
        s  = cyc + 1;
        en = 1'b1;
        wait_valid(G + 5, at);
        chk("reentry_latency", at - s, G);

        gen_on = 1'b0;
        en     = 1'b0;
        @(negedge CLK1);
        sig_in = 1'b0;
        repeat (10) @(negedge CLK1);
        s  = cyc + 1;
        en = 1'b1;
        go_to(s + 97);
        sig_in = 1'b1;
        wait_valid(G + 5, at);
        chk("term_at", at - s, G);
        chk("term_count", count8, 1);
        go_to(s + 150);
        sig_in = 1'b0;
        wait_valid(G + 5, at);
        chk("term_next", count8, 0);

        en = 1'b0;
        repeat (5) @(negedge CLK1);
        s  = cyc + 1;
        en = 1'b1;
        go_to(s + 98);
        sig_in = 1'b1;
        wait_valid(G + 5, at);
        chk("late_at", at - s, G);
        chk("late_old", count8, 0);
        wait_valid(G + 5, at);
        chk("late_new", count8, 1);
        sig_in = 1'b0;

        hi     = 5;
        lo     = 5;
        gen_on = 1'b1;
        repeat (3) wait_valid(G + 5, at);
        chk("pre_rst_count", count8, 10);
        repeat (30) @(negedge CLK1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_count", count8, 0);
        chk("arst_busy", busy8, 0);
        chk("arst_valid", valid8, 0);
        chk("arst_ovf", ovf8, 0);
        @(negedge CLK1);
        arst_n = 1'b1;
        s = cyc + 1;
        wait_valid(G + 5, at);
        chk("arst_fresh", at - s, G);

        rnd = 1'b1;
        repeat (12) begin
            repeat ($urandom_range(50, 400)) @(negedge CLK1);
            en = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge CLK1);
            en = 1'b1;
        end
        repeat (250) @(negedge CLK1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
